// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA controller.
// Command bit positions, channel count and arbiter state encoding.
package dma_pkg;

   localparam int NUM_CH         = 4;
   localparam int CMD_DISABLE    = 2;
   localparam int CMD_ROTATE     = 4;
   localparam int CMD_DREQ_SENSE = 6;
   localparam int CMD_DACK_SENSE = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      GRANT = 2'd2
   } prState_t;

endpackage

// File: rtl/dma_reg_if.sv
// Register bundle shared by the datapath (writer)
// and the priority resolver (reader).
interface DmaRegIf;

   logic [7:0] commandReg;
   logic [7:0] requestReg;
   logic [7:0] maskReg;

   modport DP (
      output commandReg,
      output requestReg,
      output maskReg
   );

   modport PR (
      input commandReg,
      input requestReg,
      input maskReg
   );

endinterface

// File: rtl/dma_rotate_arbiter.sv
// Combinational 4-way arbiter, fixed or rotating priority.
// Shared with timing control for mem-to-mem arbitration.
module dma_rotate_arbiter
   import dma_pkg::*;
(
   input  logic [NUM_CH-1:0] req_i,
   input  logic [1:0]        ptr_i,
   input  logic              rotate_i,
   output logic [1:0]        win_o,
   output logic              any_o
);

   logic [1:0] start;
   logic [1:0] idx;

   // Scan from lowest priority up so the highest-priority hit wins last
   always_comb begin
      start = rotate_i ? ptr_i : 2'd0;
      win_o = start;
      idx   = start;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = start + 2'(k);
         if (req_i[idx]) win_o = idx;
      end
   end

   // Any-request flag
   always_comb any_o = |req_i;

endmodule

// File: rtl/dma_priority_resolver.sv
// Channel arbitration: HRQ/HLDA handshake and single-channel DACK grant.
// Grant persists until service done or host abort.
module dma_priority_resolver #(
   parameter int NUM_CH = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   DmaRegIf.PR               regs,
   input  logic [NUM_CH-1:0] dreq,
   input  logic              hlda,
   input  logic              svcDone,
   output logic              hrq,
   output logic [NUM_CH-1:0] dack,
   output logic [1:0]        activeCh,
   output logic              grantValid
);

   import dma_pkg::*;

   prState_t          state_q, state_d;
   logic [1:0]        winCh_q, winCh_d;
   logic [1:0]        prioPtr_q, prioPtr_d;
   logic [NUM_CH-1:0] gnt_q, gnt_d;
   logic [NUM_CH-1:0] effReq;
   logic [1:0]        arbWin;
   logic              arbAny;
   logic              unused_bits;

   // Effective request: sensed DREQ gated by mask, plus software request
   always_comb begin
      effReq = ((dreq ^ {NUM_CH{regs.commandReg[CMD_DREQ_SENSE]}})
                & ~regs.maskReg[NUM_CH-1:0])
               | regs.requestReg[NUM_CH-1:0];
      if (regs.commandReg[CMD_DISABLE]) effReq = '0;
   end

   // Register bits this block does not consume
   always_comb unused_bits = ^{regs.commandReg[5], regs.commandReg[3],
                               regs.commandReg[1:0],
                               regs.requestReg[7:NUM_CH],
                               regs.maskReg[7:NUM_CH]};

   dma_rotate_arbiter u_arb (
      .req_i    (effReq),
      .ptr_i    (prioPtr_q),
      .rotate_i (regs.commandReg[CMD_ROTATE]),
      .win_o    (arbWin),
      .any_o    (arbAny)
   );

   // State, winner, pointer and grant registers
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q   <= IDLE;
         winCh_q   <= 2'd0;
         prioPtr_q <= 2'd0;
         gnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         winCh_q   <= winCh_d;
         prioPtr_q <= prioPtr_d;
         gnt_q     <= gnt_d;
      end
   end

   // Next-state: winner latched once in IDLE, held through REQ/GRANT
   always_comb begin
      state_d   = state_q;
      winCh_d   = winCh_q;
      prioPtr_d = prioPtr_q;
      unique case (state_q)
         IDLE: begin
            if (arbAny) begin
               state_d = REQ;
               winCh_d = arbWin;
            end
         end
         REQ: begin
            if (hlda)                  state_d = GRANT;
            else if (!effReq[winCh_q]) state_d = IDLE;
         end
         GRANT: begin
            if (svcDone) begin
               state_d   = IDLE;
               prioPtr_d = winCh_q + 2'd1;
            end else if (!hlda) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      gnt_d = '0;
      if (state_d == GRANT) gnt_d[winCh_d] = 1'b1;
   end

   // Outputs: DACK polarity applied combinationally
   always_comb begin
      dack       = gnt_q ^ {NUM_CH{~regs.commandReg[CMD_DACK_SENSE]}};
      hrq        = (state_q != IDLE);
      activeCh   = winCh_q;
      grantValid = (state_q == GRANT);
   end

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Self-checking bench: directed plan scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_dma_priority_resolver;

   logic       CLK;
   logic       RESET;
   logic [3:0] dreq;
   logic       hlda;
   logic       svcDone;
   logic       hrq;
   logic [3:0] dack;
   logic [1:0] activeCh;
   logic       grantValid;

   DmaRegIf regs_if ();

   dma_priority_resolver #(.NUM_CH(4)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .regs       (regs_if),
      .dreq       (dreq),
      .hlda       (hlda),
      .svcDone    (svcDone),
      .hrq        (hrq),
      .dack       (dack),
      .activeCh   (activeCh),
      .grantValid (grantValid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int nTests = 0;
   int nFail  = 0;

   // model: 0 = no request pending, 1 = waiting for host, 2 = channel served
   int mPh  = 0;
   int mWin = 0;
   int mPtr = 0;

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      nTests++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] eff_req();
      logic [3:0] e;
      logic [7:0] c;
      c = regs_if.commandReg;
      if (c[2]) return 4'h0;
      e = ((dreq ^ {4{c[6]}}) & ~regs_if.maskReg[3:0])
          | regs_if.requestReg[3:0];
      return e;
   endfunction

   // priority order: distance from pointer (rotating) or channel number
   function automatic int pick(input logic [3:0] e, input int ptr,
                               input bit rot);
      int best;
      int bestRank;
      int rank;
      best = -1;
      bestRank = 99;
      for (int c = 0; c < 4; c++) begin
         rank = rot ? (c - ptr + 4) % 4 : c;
         if (e[c] && rank < bestRank) begin
            best = c;
            bestRank = rank;
         end
      end
      return best;
   endfunction

   task automatic step();
      logic [3:0] e;
      logic [3:0] g;
      logic [3:0] expDack;
      e = eff_req();
      if (!RESET) begin
         mPh = 0;
         mWin = 0;
         mPtr = 0;
      end else if (mPh == 0) begin
         if (e != 0) begin
            mWin = pick(e, mPtr, regs_if.commandReg[4]);
            mPh = 1;
         end
      end else if (mPh == 1) begin
         if (hlda) mPh = 2;
         else if (!e[mWin]) mPh = 0;
      end else begin
         if (svcDone) begin
            mPtr = (mWin + 1) % 4;
            mPh = 0;
         end else if (!hlda) begin
            mPh = 0;
         end
      end
      @(posedge CLK);
      #1;
      g = (mPh == 2) ? (4'b0001 << mWin) : 4'b0000;
      expDack = g ^ (regs_if.commandReg[7] ? 4'h0 : 4'hF);
      check("hrq", {7'd0, hrq}, {7'd0, mPh != 0});
      check("grantValid", {7'd0, grantValid}, {7'd0, mPh == 2});
      check("dack", {4'd0, dack}, {4'd0, expDack});
      check("activeCh", {6'd0, activeCh}, 8'(mWin));
      check("prioPtr", {6'd0, dut.prioPtr_q}, 8'(mPtr));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_grant();
      int n;
      n = 0;
      while (!grantValid && n < 12) begin
         step();
         n++;
      end
      check("grant_wait", {7'd0, grantValid}, 8'd1);
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      step();
      RESET = 1'b1;
   endtask

   initial begin
      RESET = 1'b0;
      dreq = 4'h0;
      hlda = 1'b0;
      svcDone = 1'b0;
      regs_if.commandReg = 8'h00;
      regs_if.requestReg = 8'h00;
      regs_if.maskReg = 8'h00;

      // reset state
      step();
      check("rst_hrq", {7'd0, hrq}, 8'd0);
      check("rst_dack", {4'd0, dack}, 8'h0F);
      check("rst_active", {6'd0, activeCh}, 8'd0);
      RESET = 1'b1;

      // fixed priority
      dreq = 4'b1010;
      step();
      check("fix_hrq", {7'd0, hrq}, 8'd1);
      run(2);
      hlda = 1'b1;
      step();
      check("fix_ch", {6'd0, activeCh}, 8'd1);
      check("fix_dack", {4'd0, dack}, 8'h0D);
      svcDone = 1'b1;
      dreq = 4'b1000;
      step();
      svcDone = 1'b0;
      check("fix_idle", {7'd0, hrq}, 8'd0);
      wait_grant();
      check("fix_next", {6'd0, activeCh}, 8'd3);

      // rotating priority
      do_reset();
      regs_if.commandReg = 8'h10;
      dreq = 4'hF;
      hlda = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_grant();
         check("rot_ch", {6'd0, activeCh}, 8'(i % 4));
         svcDone = 1'b1;
         step();
         svcDone = 1'b0;
         check("rot_ptr", {6'd0, dut.prioPtr_q}, 8'((i + 1) % 4));
      end

      // mask and software request
      do_reset();
      regs_if.commandReg = 8'h00;
      regs_if.maskReg = 8'h0F;
      dreq = 4'hF;
      run(3);
      check("mask_hrq", {7'd0, hrq}, 8'd0);
      regs_if.requestReg = 8'h04;
      wait_grant();
      check("swreq_ch", {6'd0, activeCh}, 8'd2);
      regs_if.requestReg = 8'h00;
      regs_if.maskReg = 8'h00;

      // polarity
      do_reset();
      regs_if.commandReg = 8'hC0;
      dreq = 4'b1110;
      wait_grant();
      check("pol_ch", {6'd0, activeCh}, 8'd0);
      check("pol_dack", {4'd0, dack}, 8'h01);

      // withdrawal in REQ
      do_reset();
      regs_if.commandReg = 8'h00;
      hlda = 1'b0;
      dreq = 4'b0100;
      step();
      check("wd_req", {7'd0, hrq}, 8'd1);
      dreq = 4'b0000;
      step();
      check("wd_hrq", {7'd0, hrq}, 8'd0);
      check("wd_gv", {7'd0, grantValid}, 8'd0);

      // host abort in GRANT
      dreq = 4'b0100;
      hlda = 1'b1;
      wait_grant();
      hlda = 1'b0;
      step();
      check("abort_hrq", {7'd0, hrq}, 8'd0);
      check("abort_ptr", {6'd0, dut.prioPtr_q}, 8'd0);

      // reset mid-grant
      hlda = 1'b1;
      wait_grant();
      RESET = 1'b0;
      step();
      check("rstg_hrq", {7'd0, hrq}, 8'd0);
      check("rstg_dack", {4'd0, dack}, 8'h0F);
      RESET = 1'b1;

      // controller disable
      regs_if.commandReg = 8'h04;
      dreq = 4'hF;
      run(3);
      check("dis_hrq", {7'd0, hrq}, 8'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         RESET = ($urandom_range(0, 99) != 0);
         dreq = 4'($urandom);
         hlda = ($urandom_range(0, 5) != 0);
         svcDone = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0)
            regs_if.commandReg = 8'($urandom) & 8'hD4;
         if ($urandom_range(0, 15) == 0)
            regs_if.maskReg = 8'($urandom);
         if ($urandom_range(0, 15) == 0)
            regs_if.requestReg = ($urandom_range(0, 3) == 0)
                                 ? 8'($urandom) : 8'h00;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
